// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART transmitter with configurable data bits, parity and stop
// bits, fed by a valid/ready TX FIFO so frames leave back-to-back.
module uart_tx_cfg #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_BITS-1:0]        in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W        = PTR_W + 1;
  localparam int unsigned BIT_W        = $clog2(DATA_BITS);

  // Reject configurations the datapath cannot represent.
  generate
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY > 2) begin : g_bad_parity
      $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx_cfg: CLK_FREQ/BAUD_RATE must be >= 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_cfg: FIFO_DEPTH must be a power of 2, >= 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q, count_d;

  state_t               state_q;
  logic [BAUD_W-1:0]    baud_q;
  logic [BIT_W-1:0]     bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic                 tx_q;
  logic                 busy_q;

  logic                 baud_last_c, stop_last_c, push_c, pop_c, line_c, par_c;
  logic [DATA_BITS-1:0] head_c;

  assign baud_last_c = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign stop_last_c = baud_last_c && (bit_q == BIT_W'(STOP_BITS - 1));
  assign in_ready    = !rst && (count_q != CNT_W'(FIFO_DEPTH));
  assign push_c      = in_valid && in_ready;
  assign pop_c       = (count_q != '0) &&
                       ((state_q == S_IDLE) || ((state_q == S_STOP) && stop_last_c));
  assign head_c      = mem[rd_ptr_q];
  assign par_c       = (PARITY == 2) ? ^head_c : ~^head_c;

  assign tx          = tx_q;
  assign busy        = busy_q;
  assign fifo_count  = count_q;

  // Occupancy next value; a push and pop in the same cycle cancel.
  always_comb begin
    count_d = count_q;
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Line level implied by the current state; registered into tx_q one cycle later.
  always_comb begin
    line_c = 1'b1;
    case (state_q)
      S_START:  line_c = 1'b0;
      S_DATA:   line_c = shift_q[0];
      S_PARITY: line_c = par_q;
      default:  line_c = 1'b1;
    endcase
  end

  // TX FIFO storage and pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) begin
        mem[wr_ptr_q] <= in_data;
        wr_ptr_q      <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  // Frame sequencer with baud counter, bit counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      tx_q   <= line_c;
      busy_q <= (state_q != S_IDLE) || (count_q != '0) || push_c;
      if (pop_c) begin
        shift_q <= head_c;
        par_q   <= par_c;
        state_q <= S_START;
        baud_q  <= '0;
        bit_q   <= '0;
      end else begin
        case (state_q)
          S_START: begin
            if (baud_last_c) begin
              baud_q  <= '0;
              state_q <= S_DATA;
            end else begin
              baud_q <= baud_q + BAUD_W'(1);
            end
          end
          S_DATA: begin
            if (baud_last_c) begin
              baud_q  <= '0;
              shift_q <= shift_q >> 1;
              if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                bit_q   <= '0;
                state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
              end else begin
                bit_q <= bit_q + BIT_W'(1);
              end
            end else begin
              baud_q <= baud_q + BAUD_W'(1);
            end
          end
          S_PARITY: begin
            if (baud_last_c) begin
              baud_q  <= '0;
              bit_q   <= '0;
              state_q <= S_STOP;
            end else begin
              baud_q <= baud_q + BAUD_W'(1);
            end
          end
          S_STOP: begin
            if (baud_last_c) begin
              baud_q <= '0;
              if (stop_last_c) begin
                bit_q   <= '0;
                state_q <= S_IDLE;
              end else begin
                bit_q <= bit_q + BIT_W'(1);
              end
            end else begin
              baud_q <= baud_q + BAUD_W'(1);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule
